// File: rtl/fix_ari_div_if.sv
// Handshake bundle for the iterative fixed-point divider: operand request side and result side.
interface fix_ari_div_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] quotient;
  logic                    ovf;
  logic                    dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, ovf, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, ovf, dz
  );
endinterface

// File: rtl/fix_ari_div.sv
// Iterative signed Q(WIDTH-FRAC).FRAC divider, restoring on magnitudes, one quotient bit per cycle.
// Optional FIX_ARI_DIV_ROUND_EN adds a half bit and rounds half away from zero.
module fix_ari_div #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input logic         clk,
  input logic         rst,
  fix_ari_div_if.slave bus
);
  localparam int N = WIDTH + FRAC;
`ifdef FIX_ARI_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int NUM_W = N + RND;
  localparam int CNT_W = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [NUM_W-1:0]        num_q, quo_q;
  logic [WIDTH:0]          rem_q, dvs_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    fin_q, sign_q, dvd_neg_q, dz_pend_q;
  logic signed [WIDTH-1:0] quot_q;
  logic                    ovf_q, dz_q;

  // Saturate a magnitude into a signed WIDTH result; returns {ovf, quotient}.
  function automatic logic [WIDTH:0] sat_apply(input logic [NUM_W-1:0] mag, input logic neg);
    logic [NUM_W-1:0] lim;
    logic [WIDTH-1:0] low;
    lim = '0;
    lim[WIDTH-1] = 1'b1;
    low = WIDTH'(mag);
    if (neg) begin
      if (mag > lim) sat_apply = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      else           sat_apply = {1'b0, WIDTH'(-low)};
    end else begin
      if (mag >= lim) sat_apply = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
      else            sat_apply = {1'b0, low};
    end
  endfunction

  // The LSB of the raw quotient is the half bit when rounding is enabled.
  function automatic logic [NUM_W-1:0] round_mag(input logic [NUM_W-1:0] q);
`ifdef FIX_ARI_DIV_ROUND_EN
    round_mag = (q >> 1) + NUM_W'(q[0]);
`else
    round_mag = q;
`endif
  endfunction

  logic [WIDTH-1:0]        dvd_mag;
  logic signed [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]          dvs_mag;
  logic [WIDTH+1:0]        rem_sh, diff;
  logic                    q_bit;
  logic [WIDTH:0]          fin_res;

  always_comb begin
    dvd_mag = bus.dividend[WIDTH-1] ? WIDTH'(-bus.dividend) : WIDTH'(bus.dividend);
    dvs_ext = {bus.divisor[WIDTH-1], bus.divisor};
    dvs_mag = dvs_ext[WIDTH] ? (WIDTH+1)'(-dvs_ext) : (WIDTH+1)'(dvs_ext);
    rem_sh  = {rem_q, num_q[NUM_W-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    q_bit   = (rem_sh >= {1'b0, dvs_q});
    if (dz_pend_q)
      fin_res = dvd_neg_q ? {1'b0, 1'b1, {(WIDTH-1){1'b0}}} : {1'b0, 1'b0, {(WIDTH-1){1'b1}}};
    else
      fin_res = sat_apply(round_mag(quo_q), sign_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: if (fin_q) state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A divide-by-zero sets fin_q at acceptance, so it spends exactly one finalize cycle in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q <= '0; quo_q <= '0; rem_q <= '0; dvs_q <= '0; cnt_q <= '0;
      fin_q <= 1'b0; sign_q <= 1'b0; dvd_neg_q <= 1'b0; dz_pend_q <= 1'b0;
      quot_q <= '0; ovf_q <= 1'b0; dz_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          num_q     <= {dvd_mag, {(FRAC+RND){1'b0}}};
          quo_q     <= '0;
          rem_q     <= '0;
          dvs_q     <= dvs_mag;
          cnt_q     <= CNT_W'(NUM_W - 1);
          sign_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          dvd_neg_q <= bus.dividend[WIDTH-1];
          dz_pend_q <= (bus.divisor == '0);
          fin_q     <= (bus.divisor == '0);
        end
        CALC: if (!fin_q) begin
          rem_q <= q_bit ? (WIDTH+1)'(diff) : (WIDTH+1)'(rem_sh);
          num_q <= num_q << 1;
          quo_q <= {quo_q[NUM_W-2:0], q_bit};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) fin_q <= 1'b1;
        end else begin
          quot_q <= fin_res[WIDTH-1:0];
          ovf_q  <= fin_res[WIDTH];
          dz_q   <= dz_pend_q;
          fin_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient = quot_q;
  assign bus.ovf      = ovf_q;
  assign bus.dz       = dz_q;
endmodule

// File: tb/tb_fix_ari_div.sv
// Directed-vector bench for fix_ari_div: table of divisions plus backpressure and abort sequences.
module tb_fix_ari_div;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
`ifdef FIX_ARI_DIV_ROUND_EN
  localparam int LAT = 26;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 25;
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fix_ari_div_if #(.WIDTH(WIDTH)) bus ();
  fix_ari_div #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] q;
    logic                    ovf;
    logic                    dz;
    string                   nm;
  } vec_t;

  vec_t tbl[15];

  task automatic run_op(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                        input logic signed [WIDTH-1:0] eq, input logic eo, input logic ed,
                        input int elat, input string nm);
    int lat;
    bit rdy_bad;
    check({nm, "_in_ready_idle"}, int'(bus.in_ready), 1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = -1;
    rdy_bad = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.in_ready) rdy_bad = 1'b1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check({nm, "_latency"}, lat, elat);
    check({nm, "_in_ready_busy"}, int'(rdy_bad), 0);
    check({nm, "_quotient"}, int'(bus.quotient), int'(eq));
    check({nm, "_ovf"}, int'(bus.ovf), int'(eo));
    check({nm, "_dz"}, int'(bus.dz), int'(ed));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({nm, "_out_valid_drop"}, int'(bus.out_valid), 0);
    check({nm, "_quotient_kept"}, int'(bus.quotient), int'(eq));
  endtask

  initial begin
    bit bad;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    tbl[0]  = '{16'sd768,    16'sd512,   16'sd384,    1'b0, 1'b0, "v3_0_by_2_0"};
    tbl[1]  = '{-16'sd1024,  16'sd8192,  -16'sd32,    1'b0, 1'b0, "neg_by_pos"};
    tbl[2]  = '{16'sd1023,   -16'sd8195, RND ? -16'sd32 : -16'sd31, 1'b0, 1'b0, "trunc_pos_by_neg"};
    tbl[3]  = '{16'sd32767,  16'sd1,     16'sd32767,  1'b1, 1'b0, "ovf_pos"};
    tbl[4]  = '{-16'sd32768, 16'sd1,     -16'sd32768, 1'b1, 1'b0, "ovf_neg"};
    tbl[5]  = '{-16'sd32768, 16'sd256,   -16'sd32768, 1'b0, 1'b0, "min_by_one"};
    tbl[6]  = '{16'sd500,    16'sd0,     16'sd32767,  1'b0, 1'b1, "dz_pos"};
    tbl[7]  = '{-16'sd500,   16'sd0,     -16'sd32768, 1'b0, 1'b1, "dz_neg"};
    tbl[8]  = '{16'sd512,    16'sd768,   RND ? 16'sd171 : 16'sd170, 1'b0, 1'b0, "two_thirds"};
    tbl[9]  = '{-16'sd512,   16'sd768,   RND ? -16'sd171 : -16'sd170, 1'b0, 1'b0, "neg_two_thirds"};
    tbl[10] = '{16'sd0,      16'sd100,   16'sd0,      1'b0, 1'b0, "zero_dividend"};
    tbl[11] = '{16'sd32767,  16'sd256,   16'sd32767,  1'b0, 1'b0, "max_by_one"};
    tbl[12] = '{16'sd5,      16'sd512,   RND ? 16'sd3 : 16'sd2, 1'b0, 1'b0, "half_tie"};
    tbl[13] = '{16'sd100,    -16'sd256,  -16'sd100,   1'b0, 1'b0, "by_minus_one"};
    tbl[14] = '{-16'sd7,     -16'sd512,  RND ? 16'sd4 : 16'sd3, 1'b0, 1'b0, "neg_by_neg"};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_quotient", int'(bus.quotient), 0);
    check("reset_ovf", int'(bus.ovf), 0);
    check("reset_dz", int'(bus.dz), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].ovf, tbl[i].dz,
             tbl[i].dz ? 1 : LAT, tbl[i].nm);

    // Backpressure: result held while new operands are offered.
    bus.dividend = 16'sd768;
    bus.divisor  = 16'sd512;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.dividend = 16'sd100;
    bus.divisor  = 16'sd3;
    for (int k = 0; k < LAT + 5 && !bus.out_valid; k++) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid", int'(bus.out_valid), 1);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.quotient != 16'sd384 || bus.in_ready || !bus.out_valid) bad = 1'b1;
    end
    check("bp_hold_stable", int'(bad), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_out_valid", int'(bus.out_valid), 0);
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    check("bp_quotient_kept", int'(bus.quotient), 384);

    // Abort during the tenth iteration.
    bus.dividend = 16'sd768;
    bus.divisor  = 16'sd512;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_quotient", int'(bus.quotient), 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) bad = 1'b1;
    end
    check("abort_no_result", int'(bad), 0);

    run_op(16'sd768, 16'sd512, 16'sd384, 1'b0, 1'b0, LAT, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
